// File: rtl/spi_ram_arbiter_if.sv
// Purpose: bundles the fetch port, the data port and the SPI pins of spi_ram_arbiter.
// Ports: fetch req/addr/ack/rdata, data req/we/addr/wdata/ack/rdata, busy, spi cs/sck/mosi/miso.
// Modports: slave = arbiter side, master = core/pin side.
interface spi_ram_arbiter_if;
    logic        f_req;
    logic [15:0] f_addr;
    logic        f_ack;
    logic [15:0] f_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_ack;
    logic [15:0] d_rdata;
    logic        busy;
    logic        spi_cs;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, spi_miso,
        output f_ack, f_rdata, d_ack, d_rdata, busy, spi_cs, spi_sck, spi_mosi
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, spi_miso,
        input  f_ack, f_rdata, d_ack, d_rdata, busy, spi_cs, spi_sck, spi_mosi
    );
endinterface

// File: rtl/spi_ram_arbiter.sv
// Purpose: round-robin SPI RAM controller for a read-only fetch port and a read/write data port,
//          with a one-entry fetch cache. Ports: clk, rst (sync, active high), bus (slave modport).
// Latency: ack 81 cycles after the grant cycle for SPI transfers, next cycle for a cache hit.
// Backpressure: requests are held until their one-cycle ack; losing port waits for the next IDLE.
module spi_ram_arbiter #(
    parameter int unsigned FETCH_CACHE = 1,
    parameter int unsigned CS_HIGH_MIN = 1,
    parameter logic [7:0]  READ_CMD    = 8'h03,
    parameter logic [7:0]  WRITE_CMD   = 8'h02
) (
    input  logic            clk,
    input  logic            rst,
    spi_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, CSHIGH} state_t;

    localparam logic [7:0] HI_LAST = 8'(CS_HIGH_MIN - 1);

    state_t      state;
    logic [39:0] sh;          // {cmd, addr, wdata}; MSB drives mosi
    logic [5:0]  bit_cnt;
    logic [14:0] rx;
    logic [7:0]  hi_cnt;
    logic        last_d;      // 1 = data port had the last grant
    logic        cur_d;
    logic        cur_we;
    logic [15:0] cur_addr;
    logic [15:0] cur_wdata;
    logic        cache_vld;
    logic [15:0] cache_addr;
    logic [15:0] cache_data;
    logic        f_ack_q, d_ack_q;
    logic [15:0] f_rdata_q, d_rdata_q;
    logic        cs_q, sck_q;

    logic        hit, f_cand, grant_d, grant_f, g_we;
    logic [15:0] g_addr, rd_word;

    // A cache hit is serviced directly and never competes for the bus.
    assign hit     = (FETCH_CACHE != 0) && cache_vld && bus.f_req && (bus.f_addr == cache_addr);
    assign f_cand  = bus.f_req && !hit;
    assign grant_d = bus.d_req && (!f_cand || !last_d);
    assign grant_f = f_cand && (!bus.d_req || last_d);
    assign g_we    = grant_d && bus.d_we;
    assign g_addr  = grant_d ? bus.d_addr : bus.f_addr;
    // The last data bit is still on miso at the final sampling edge.
    assign rd_word = {rx, bus.spi_miso};

    assign bus.f_ack    = f_ack_q;
    assign bus.f_rdata  = f_rdata_q;
    assign bus.d_ack    = d_ack_q;
    assign bus.d_rdata  = d_rdata_q;
    assign bus.busy     = (state != IDLE);
    assign bus.spi_cs   = cs_q;
    assign bus.spi_sck  = sck_q;
    // The shift word empties to zero after 40 shifts, so mosi idles low.
    assign bus.spi_mosi = sh[39];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sh         <= '0;
            bit_cnt    <= '0;
            rx         <= '0;
            hi_cnt     <= '0;
            last_d     <= 1'b0;
            cur_d      <= 1'b0;
            cur_we     <= 1'b0;
            cur_addr   <= '0;
            cur_wdata  <= '0;
            cache_vld  <= 1'b0;
            cache_addr <= '0;
            cache_data <= '0;
            f_ack_q    <= 1'b0;
            d_ack_q    <= 1'b0;
            f_rdata_q  <= '0;
            d_rdata_q  <= '0;
            cs_q       <= 1'b1;
            sck_q      <= 1'b0;
        end else begin
            f_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (hit) begin
                        f_ack_q   <= 1'b1;
                        f_rdata_q <= cache_data;
                    end
                    if (grant_d || grant_f) begin
                        sh        <= {g_we ? WRITE_CMD : READ_CMD, g_addr,
                                      g_we ? bus.d_wdata : 16'h0000};
                        cs_q      <= 1'b0;
                        sck_q     <= 1'b0;
                        bit_cnt   <= '0;
                        last_d    <= grant_d;
                        cur_d     <= grant_d;
                        cur_we    <= g_we;
                        cur_addr  <= g_addr;
                        cur_wdata <= bus.d_wdata;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!sck_q) begin
                        sck_q <= 1'b1;
                    end else begin
                        sck_q   <= 1'b0;
                        sh      <= {sh[38:0], 1'b0};
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt >= 6'd24 && !cur_we)
                            rx <= {rx[13:0], bus.spi_miso};
                        if (bit_cnt == 6'd39) begin
                            cs_q   <= 1'b1;
                            hi_cnt <= '0;
                            state  <= CSHIGH;
                            if (cur_d) begin
                                d_ack_q <= 1'b1;
                                if (!cur_we)
                                    d_rdata_q <= rd_word;
                                else if (cache_vld && cur_addr == cache_addr)
                                    cache_data <= cur_wdata;
                            end else begin
                                f_ack_q    <= 1'b1;
                                f_rdata_q  <= rd_word;
                                cache_vld  <= 1'b1;
                                cache_addr <= cur_addr;
                                cache_data <= rd_word;
                            end
                        end
                    end
                end
                CSHIGH: begin
                    if (hi_cnt == HI_LAST)
                        state <= IDLE;
                    else
                        hi_cnt <= hi_cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    spi_ram_arbiter_if bus();
    spi_ram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] dat;
        int          lat;   // -1 when arbitration makes latency unpredictable
        int          t0;
    } exp_t;

    exp_t        f_exp[$];
    exp_t        d_exp[$];
    logic [39:0] frm_exp[$];
    exp_t        fe, de;

    logic [15:0] slv_mem [logic [15:0]];
    logic [15:0] ref_mem [logic [15:0]];

    // reference model state
    bit          m_cvld = 0;
    logic [15:0] m_caddr = '0, m_cdat = '0, m_dlast = '0;
    logic [15:0] mon_flast = '0, mon_dlast = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] init_val(input logic [15:0] a);
        return 16'((32'(a) * 40503) + 23130);
    endfunction

    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [15:0] slv_rd(input logic [15:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    task automatic preload(input logic [15:0] a, input logic [15:0] v);
        slv_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // High-level model: what a fetch returns and whether it touches the bus.
    task automatic m_fetch(input logic [15:0] a, output exp_t e);
        bit hit;
        hit   = m_cvld && (a == m_caddr);
        e.dat = hit ? m_cdat : ref_rd(a);
        e.lat = hit ? 1 : 81;
        e.t0  = 0;
        if (!hit) frm_exp.push_back({8'h03, a, 16'h0000});
        m_cvld  = 1;
        m_caddr = a;
        m_cdat  = e.dat;
    endtask

    task automatic m_data(input bit we, input logic [15:0] a, input logic [15:0] wd, output exp_t e);
        e.lat = 81;
        e.t0  = 0;
        if (we) begin
            e.dat      = m_dlast;
            ref_mem[a] = wd;
            if (m_cvld && a == m_caddr) m_cdat = wd;
            frm_exp.push_back({8'h02, a, wd});
        end else begin
            e.dat   = ref_rd(a);
            m_dlast = e.dat;
            frm_exp.push_back({8'h03, a, 16'h0000});
        end
    endtask

    task automatic wait_ack(input bit is_d);
        bit got;
        got = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (is_d ? bus.d_ack : bus.f_ack) begin
                got = 1;
                break;
            end
        end
        chk(is_d ? "d_ack_timeout" : "f_ack_timeout", 64'(got), 64'd1);
    endtask

    task automatic fetch(input logic [15:0] a);
        exp_t e;
        m_fetch(a, e);
        @(posedge clk); #1;
        e.t0 = cyc;
        f_exp.push_back(e);
        bus.f_addr = a;
        bus.f_req  = 1'b1;
        wait_ack(0);
        bus.f_req  = 1'b0;
        bus.f_addr = 16'($urandom);
    endtask

    task automatic data(input bit we, input logic [15:0] a, input logic [15:0] wd);
        exp_t e;
        m_data(we, a, wd, e);
        @(posedge clk); #1;
        e.t0 = cyc;
        d_exp.push_back(e);
        bus.d_addr  = a;
        bus.d_we    = we;
        bus.d_wdata = wd;
        bus.d_req   = 1'b1;
        wait_ack(1);
        bus.d_req   = 1'b0;
        bus.d_addr  = 16'($urandom);
        bus.d_wdata = 16'($urandom);
    endtask

    task automatic model_reset();
        m_cvld    = 0;
        m_dlast   = '0;
        mon_flast = '0;
        mon_dlast = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.f_req = 1'b0;
        bus.d_req = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    task automatic chk_idle(input string tag);
        @(negedge clk);
        chk({tag, "_cs"},      64'(bus.spi_cs),   64'd1);
        chk({tag, "_sck"},     64'(bus.spi_sck),  64'd0);
        chk({tag, "_mosi"},    64'(bus.spi_mosi), 64'd0);
        chk({tag, "_busy"},    64'(bus.busy),     64'd0);
        chk({tag, "_f_ack"},   64'(bus.f_ack),    64'd0);
        chk({tag, "_d_ack"},   64'(bus.d_ack),    64'd0);
        chk({tag, "_f_rdata"}, 64'(bus.f_rdata),  64'd0);
        chk({tag, "_d_rdata"}, 64'(bus.d_rdata),  64'd0);
    endtask

    // Ack scoreboard monitor
    always @(negedge clk) begin
        if (bus.f_ack) begin
            if (f_exp.size() == 0) begin
                chk("f_ack_unexpected", 64'(bus.f_ack), 64'd0);
            end else begin
                fe = f_exp.pop_front();
                chk("f_rdata", 64'(bus.f_rdata), 64'(fe.dat));
                if (fe.lat >= 0) chk("f_latency", 64'(cyc - fe.t0), 64'(fe.lat));
                chk("d_rdata_held", 64'(bus.d_rdata), 64'(mon_dlast));
                mon_flast = fe.dat;
            end
        end
        if (bus.d_ack) begin
            if (d_exp.size() == 0) begin
                chk("d_ack_unexpected", 64'(bus.d_ack), 64'd0);
            end else begin
                de = d_exp.pop_front();
                chk("d_rdata", 64'(bus.d_rdata), 64'(de.dat));
                if (de.lat >= 0) chk("d_latency", 64'(cyc - de.t0), 64'(de.lat));
                chk("f_rdata_held", 64'(bus.f_rdata), 64'(mon_flast));
                mon_dlast = de.dat;
            end
        end
    end

    // SPI RAM slave and frame monitor
    logic [39:0] fsh = '0;
    logic [15:0] miso_sh = '0;
    int  nbits = 0, low_cyc = 0, gap = 0, wins = 0, abort_cnt = 0;
    bit  in_win = 0, busy_low = 0;

    always @(negedge clk) begin
        if (!bus.spi_cs) begin
            if (!in_win) begin
                in_win   = 1;
                nbits    = 0;
                low_cyc  = 0;
                busy_low = 0;
                if (wins > 0) chk("cs_high_gap", 64'(gap >= 2), 64'd1);
            end
            low_cyc++;
            if (!bus.busy) busy_low = 1;
            if (bus.spi_sck) begin
                fsh = {fsh[38:0], bus.spi_mosi};
                nbits++;
                if (nbits == 24) miso_sh = slv_rd(fsh[15:0]);
                if (nbits >= 25) begin
                    bus.spi_miso = miso_sh[15];
                    miso_sh = {miso_sh[14:0], 1'b0};
                end
                if (nbits == 40 && fsh[39:32] == 8'h02) slv_mem[fsh[31:16]] = fsh[15:0];
            end
        end else if (in_win) begin
            in_win = 0;
            bus.spi_miso = 1'b0;
            gap = 1;
            wins++;
            if (nbits == 40) begin
                chk("cs_low_cycles", 64'(low_cyc), 64'd80);
                chk("busy_during_cs", 64'(busy_low), 64'd0);
                if (frm_exp.size() == 0) chk("spi_frame_unexpected", 64'(nbits), 64'd0);
                else chk("spi_frame", 64'(fsh), 64'(frm_exp.pop_front()));
            end else begin
                abort_cnt++;
            end
        end else begin
            gap++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        bus.f_req = 0; bus.f_addr = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.spi_miso = 0;

        do_reset();
        chk_idle("reset");
        preload(16'h0010, 16'hABCD);
        preload(16'h00FF, 16'h8001);

        fetch(16'h0010);               // miss: 03 0010, returns ABCD
        fetch(16'h0010);               // hit, no SPI
        data(1, 16'h0010, 16'h1234);   // 02 0010 1234, write-through
        fetch(16'h0010);               // hit returns 1234
        data(0, 16'h00FF, 16'h0000);   // read 8001, f_rdata held
        fetch(16'h0010);               // cache unaffected by data read

        // Both ports pending from reset: data, fetch, data, fetch.
        do_reset();
        @(posedge clk); #1;
        m_data(1, 16'h0100, 16'h5555, e);  e.lat = -1; d_exp.push_back(e);
        m_fetch(16'h0200, e);              e.lat = -1; f_exp.push_back(e);
        m_data(0, 16'h0101, 16'h0000, e);  e.lat = -1; d_exp.push_back(e);
        m_fetch(16'h0201, e);              e.lat = -1; f_exp.push_back(e);
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    bus.f_addr = (i == 0) ? 16'h0200 : 16'h0201;
                    bus.f_req  = 1'b1;
                    wait_ack(0);
                end
                bus.f_req = 1'b0;
            end
            begin
                for (int j = 0; j < 2; j++) begin
                    bus.d_addr  = (j == 0) ? 16'h0100 : 16'h0101;
                    bus.d_we    = (j == 0);
                    bus.d_wdata = 16'h5555;
                    bus.d_req   = 1'b1;
                    wait_ack(1);
                end
                bus.d_req = 1'b0;
            end
        join

        // Reset at bit 20 of a fetch: abort, no ack, cache invalidated.
        fetch(16'h0040);
        @(posedge clk); #1;
        bus.f_addr = 16'h0050;
        bus.f_req  = 1'b1;
        repeat (41) @(posedge clk);
        #1 rst = 1'b1;
        bus.f_req = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("abort_cs",   64'(bus.spi_cs),  64'd1);
        chk("abort_sck",  64'(bus.spi_sck), 64'd0);
        chk("abort_busy", 64'(bus.busy),    64'd0);
        repeat (5) @(negedge clk);
        fetch(16'h0040);               // must be a full SPI read
        fetch(16'h0050);

        for (int k = 0; k < 40; k++) begin
            int unsigned r;
            logic [15:0] a;
            r = $urandom_range(0, 3);
            a = 16'h0020 + 16'($urandom_range(0, 3));
            if (r < 2) fetch(a);
            else data(r == 3, a, 16'($urandom));
        end

        repeat (10) @(negedge clk);
        chk("frames_left", 64'(frm_exp.size()), 64'd0);
        chk("f_exp_left",  64'(f_exp.size()),   64'd0);
        chk("d_exp_left",  64'(d_exp.size()),   64'd0);
        chk("abort_count", 64'(abort_cnt),      64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
